// File: rtl/sd_cmd_framer_if.sv
// Command-request, transmit-FIFO write and SPI-master control signals of the SD command framer.
// The slave modport is the framer's view; master is the view of whatever drives it.
interface sd_cmd_framer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [5:0]  resp_len;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full;
  logic        spi_start;
  logic [5:0]  cmd_length;
  logic [5:0]  response_length;
  logic [9:0]  send_data_length;
  logic [9:0]  receive_data_length;
  logic        spi_busy;
  logic        spi_valid;
  logic        busy;
  logic        done;
  logic        timeout;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, resp_len, fifo_full, spi_busy, spi_valid,
    output cmd_ready, fifo_wr_en, fifo_wr_data, spi_start, cmd_length, response_length,
           send_data_length, receive_data_length, busy, done, timeout
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg, resp_len, fifo_full, spi_busy, spi_valid,
    input  cmd_ready, fifo_wr_en, fifo_wr_data, spi_start, cmd_length, response_length,
           send_data_length, receive_data_length, busy, done, timeout
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// Builds a 6-byte SPI-mode SD command frame with a bit-serial CRC7, pushes it into the
// SPI master's transmit FIFO, then runs the start/busy/valid handshake with a timeout.
module sd_cmd_framer #(
  parameter int CMD_LEN     = 6,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  sd_cmd_framer_if.slave   bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC,
    S_PUSH,
    S_START,
    S_WAIT
  } state_t;

  state_t           state_q;
  logic [47:0]      frame_q;
  logic [6:0]       crc_q;
  logic [5:0]       bit_cnt_q;
  logic [2:0]       byte_cnt_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic             cmd_ready_q;
  logic             fifo_wr_en_q;
  logic [7:0]       fifo_wr_data_q;
  logic             spi_start_q;
  logic [5:0]       resp_len_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;

  logic [5:0]       bit_idx;
  logic             crc_fb;
  logic [6:0]       crc_d;
  logic [7:0]       cur_byte;
  logic             to_hit;

  // CRC7 (x^7 + x^3 + 1) advanced one frame bit per cycle, MSB of the frame first.
  always_comb begin
    bit_idx = 6'd47 - bit_cnt_q;
    crc_fb  = frame_q[bit_idx] ^ crc_q[6];
    crc_d   = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  end

  always_comb begin
    case (byte_cnt_q)
      3'd0:    cur_byte = frame_q[47:40];
      3'd1:    cur_byte = frame_q[39:32];
      3'd2:    cur_byte = frame_q[31:24];
      3'd3:    cur_byte = frame_q[23:16];
      3'd4:    cur_byte = frame_q[15:8];
      default: cur_byte = frame_q[7:0];
    endcase
  end

  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      frame_q        <= '0;
      crc_q          <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      to_cnt_q       <= '0;
      cmd_ready_q    <= 1'b1;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      spi_start_q    <= 1'b0;
      resp_len_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      fifo_wr_en_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            frame_q     <= {2'b01, bus.cmd_index, bus.cmd_arg, 8'h00};
            resp_len_q  <= bus.resp_len;
            crc_q       <= '0;
            bit_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_CRC;
          end
        end
        S_CRC: begin
          crc_q     <= crc_d;
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd39) begin
            frame_q[7:0] <= {crc_d, 1'b1};
            byte_cnt_q   <= '0;
            state_q      <= S_PUSH;
          end
        end
        S_PUSH: begin
          // A full FIFO simply stalls the byte pointer; the pending byte is retried.
          if (!bus.fifo_full) begin
            fifo_wr_en_q   <= 1'b1;
            fifo_wr_data_q <= cur_byte;
            if (byte_cnt_q == 3'd5) begin
              to_cnt_q <= '0;
              state_q  <= S_START;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        S_START: begin
          // The master only samples on its SCK tick, so start is held as a level until busy.
          if (to_hit) begin
            timeout_q   <= 1'b1;
            spi_start_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (bus.spi_busy) begin
            spi_start_q <= 1'b0;
            to_cnt_q    <= to_cnt_q + 1'b1;
            state_q     <= S_WAIT;
          end else begin
            spi_start_q <= 1'b1;
            to_cnt_q    <= to_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.spi_busy && bus.spi_valid) begin
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (to_hit) begin
            timeout_q   <= 1'b1;
            spi_start_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready           = cmd_ready_q;
  assign bus.fifo_wr_en          = fifo_wr_en_q;
  assign bus.fifo_wr_data        = fifo_wr_data_q;
  assign bus.spi_start           = spi_start_q;
  assign bus.cmd_length          = 6'(CMD_LEN);
  assign bus.response_length     = resp_len_q;
  assign bus.send_data_length    = '0;
  assign bus.receive_data_length = '0;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.timeout             = timeout_q;
endmodule

// File: tb/tb_sd_cmd_framer.sv
// Bench for sd_cmd_framer: known SD command vectors, FIFO stalls, back-to-back requests,
// async reset mid-push, a short-timeout instance, and random commands against a CRC7 model.
module tb_sd_cmd_framer;
  localparam int TO_SHORT = 50;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [5:0]  rl;
    logic [47:0] exp;
    int          busy_cyc;
    int          stall;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_cmd_framer_if ifm ();
  sd_cmd_framer_if ift ();

  sd_cmd_framer #(.CMD_LEN(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifm.slave)
  );

  sd_cmd_framer #(.CMD_LEN(6), .TIMEOUT_CYC(TO_SHORT)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ift.slave)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] wr_q[$];
  int         done_cnt, to_cnt, first_wr_cyc, full_viol, stall_low;
  bit         full_prev;
  int         t_wr, t_done, t_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  // One clock cycle; all DUT sampling happens here on the falling edge.
  task automatic tick();
    full_prev = ifm.fifo_full;
    @(negedge clk);
    cyc++;
    if (ifm.fifo_wr_en) begin
      if (wr_q.size() == 0) first_wr_cyc = cyc;
      if (full_prev) full_viol++;
      wr_q.push_back(ifm.fifo_wr_data);
    end
    if (ifm.done) done_cnt++;
    if (ifm.timeout) to_cnt++;
    if (ift.fifo_wr_en) t_wr++;
    if (ift.done) t_done++;
    if (ift.timeout) t_to++;
  endtask

  task automatic run_cmd(input string nm, input vec_t v, input bit rand_full,
                         input bit pend, input vec_t nv);
    int acc, t;
    logic [47:0] got;
    t = 0;
    while (!ifm.cmd_ready && t < 100) begin tick(); t++; end
    chk({nm, "_ready_before"}, ifm.cmd_ready, 1'b1);
    ifm.cmd_valid = 1'b1; ifm.cmd_index = v.idx; ifm.cmd_arg = v.arg; ifm.resp_len = v.rl;
    tick();
    acc = cyc;
    wr_q.delete(); done_cnt = 0; to_cnt = 0; full_viol = 0; stall_low = 0;
    chk({nm, "_accept_ready"}, ifm.cmd_ready, 1'b0);
    chk({nm, "_accept_busy"}, ifm.busy, 1'b1);
    if (pend) begin
      ifm.cmd_index = nv.idx; ifm.cmd_arg = nv.arg; ifm.resp_len = nv.rl;
    end else begin
      ifm.cmd_valid = 1'b0;
      ifm.cmd_index = 6'($urandom); ifm.cmd_arg = $urandom; ifm.resp_len = 6'($urandom);
    end
    chk({nm, "_resp_len"}, ifm.response_length, v.rl);
    begin
      int stall_left;
      stall_left = v.stall;
      t = 0;
      while (!ifm.spi_start && t < 400) begin
        if (v.stall > 0 && wr_q.size() == 2 && stall_left > 0) begin
          ifm.fifo_full = 1'b1; stall_left--;
        end else if (rand_full) ifm.fifo_full = ($urandom_range(0, 2) == 0);
        else ifm.fifo_full = 1'b0;
        tick(); t++;
        if (full_prev && v.stall > 0 && !ifm.fifo_wr_en) stall_low++;
      end
    end
    ifm.fifo_full = 1'b0;
    chk({nm, "_start_seen"}, ifm.spi_start, 1'b1);
    if (!rand_full && v.stall == 0) begin
      chk({nm, "_first_wr_lat"}, first_wr_cyc - acc, 41);
      chk({nm, "_start_lat"}, cyc - acc, 47);
    end
    chk({nm, "_wr_count"}, wr_q.size(), 6);
    got = '0;
    foreach (wr_q[i]) got = {got[39:0], wr_q[i]};
    chk({nm, "_frame"}, got, v.exp);
    chk({nm, "_wr_while_full"}, full_viol, 0);
    if (v.stall > 0) chk({nm, "_stall_low"}, stall_low, v.stall);
    ifm.spi_busy = 1'b1;
    tick();
    chk({nm, "_start_drop"}, ifm.spi_start, 1'b0);
    for (int i = 1; i < v.busy_cyc; i++) tick();
    chk({nm, "_busy_wait"}, ifm.busy, 1'b1);
    ifm.spi_busy = 1'b0; ifm.spi_valid = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 5) begin tick(); t++; end
    ifm.spi_valid = 1'b0;
    chk({nm, "_done_lat"}, t, 1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_ready_after"}, ifm.cmd_ready, 1'b1);
    chk({nm, "_no_timeout"}, to_cnt, 0);
    if (!pend) begin
      tick();
      chk({nm, "_done_once"}, done_cnt, 1);
      chk({nm, "_idle_busy"}, ifm.busy, 1'b0);
    end
  endtask

  vec_t tbl[5];

  initial begin
    vec_t rv, nul;
    int acc, t;
    bit start_seen;

    tbl[0] = '{6'd0,  32'h0000_0000, 6'd1, 48'h40_00_00_00_00_95, 5,   0};
    tbl[1] = '{6'd8,  32'h0000_01AA, 6'd5, 48'h48_00_00_01_AA_87, 100, 0};
    tbl[2] = '{6'd55, 32'h0000_0000, 6'd1, 48'h77_00_00_00_00_65, 10,  0};
    tbl[3] = '{6'd41, 32'h4000_0000, 6'd1, 48'h69_40_00_00_00_77, 10,  0};
    tbl[4] = '{6'd0,  32'h0000_0000, 6'd1, 48'h40_00_00_00_00_95, 3,   3};
    nul    = '{6'd0, 32'h0, 6'd0, 48'h0, 1, 0};

    ifm.cmd_valid = 0; ifm.cmd_index = 0; ifm.cmd_arg = 0; ifm.resp_len = 0;
    ifm.fifo_full = 0; ifm.spi_busy = 0; ifm.spi_valid = 0;
    ift.cmd_valid = 0; ift.cmd_index = 0; ift.cmd_arg = 0; ift.resp_len = 0;
    ift.fifo_full = 0; ift.spi_busy = 0; ift.spi_valid = 0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", ifm.cmd_ready, 1'b1);
    chk("rst_busy", ifm.busy, 1'b0);
    chk("rst_wr_en", ifm.fifo_wr_en, 1'b0);
    chk("rst_spi_start", ifm.spi_start, 1'b0);
    chk("rst_resp_len", ifm.response_length, 6'd0);
    chk("const_cmd_length", ifm.cmd_length, 6'd6);
    chk("const_lengths", {ifm.send_data_length, ifm.receive_data_length}, 20'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table vectors; entry 2 holds the next request valid throughout so it must be ignored.
    for (int i = 0; i < 5; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i], 1'b0, (i == 2), (i == 2) ? tbl[3] : nul);

    // Async reset after the third byte, then a fresh CMD0.
    ifm.cmd_valid = 1'b1; ifm.cmd_index = 6'd0; ifm.cmd_arg = 0; ifm.resp_len = 6'd1;
    tick();
    ifm.cmd_valid = 1'b0;
    wr_q.delete();
    t = 0;
    while (wr_q.size() < 3 && t < 100) begin tick(); t++; end
    chk("rstmid_bytes_before", wr_q.size(), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cmd_ready", ifm.cmd_ready, 1'b1);
    chk("rstmid_busy", ifm.busy, 1'b0);
    chk("rstmid_wr", {ifm.fifo_wr_en, ifm.fifo_wr_data}, 9'd0);
    chk("rstmid_start", ifm.spi_start, 1'b0);
    chk("rstmid_resp_len", ifm.response_length, 6'd0);
    chk("rstmid_pulses", {ifm.done, ifm.timeout}, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_cmd("after_rst", tbl[0], 1'b0, 1'b0, nul);

    // Short-timeout instance: the master never reports busy.
    t_wr = 0; t_done = 0; t_to = 0;
    ift.cmd_valid = 1'b1;
    tick();
    acc = cyc;
    ift.cmd_valid = 1'b0;
    chk("to_accept", ift.cmd_ready, 1'b0);
    t = 0; start_seen = 0;
    while (t_to == 0 && t < 300) begin
      tick(); t++;
      if (ift.spi_start) start_seen = 1;
    end
    chk("to_start_seen", start_seen, 1'b1);
    chk("to_latency", cyc - acc, 46 + TO_SHORT);
    chk("to_start_low", ift.spi_start, 1'b0);
    chk("to_idle", {ift.cmd_ready, ift.busy}, 2'b10);
    chk("to_writes", t_wr, 6);
    for (int i = 0; i < 5; i++) tick();
    chk("to_pulse_once", t_to, 1);
    chk("to_no_done", t_done, 0);

    // Random commands with random FIFO back-pressure against the reference model.
    for (int i = 0; i < 8; i++) begin
      rv.idx = 6'($urandom);
      rv.arg = $urandom;
      rv.rl = 6'($urandom_range(1, 5));
      rv.exp = frame_ref(rv.idx, rv.arg);
      rv.busy_cyc = $urandom_range(1, 20);
      rv.stall = 0;
      run_cmd($sformatf("rand%0d", i), rv, 1'b1, 1'b0, nul);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
